// File: rtl/ps2_pkg.sv
// Shared types and command constants for the PS/2 host transmit path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Multi-stage synchroniser for the PS/2 clock and data lines plus clock falling-edge detect.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_q;
  logic [SYNC_STAGES-1:0] dat_q;
  logic                   clk_d;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_q <= '1;
      dat_q <= '1;
      clk_d <= 1'b1;
    end else begin
      clk_q <= {clk_q[SYNC_STAGES-2:0], ps2_clk};
      dat_q <= {dat_q[SYNC_STAGES-2:0], ps2_dat};
      clk_d <= clk_q[SYNC_STAGES-1];
    end
  end

  assign clk_s    = clk_q[SYNC_STAGES-1];
  assign dat_s    = dat_q[SYNC_STAGES-1];
  assign clk_fall = clk_d & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-collector enables.
// Optional PS2_TX_RETRY_EN: up to two automatic retries before TX_ERR.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET_H,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE,
  output logic       TX_DONE,
  output logic       TX_ERR
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [19:0]      TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state;
  logic [INH_W-1:0] inh_cnt;
  logic [19:0]      tmo_cnt;
  logic [3:0]       bit_cnt;
  logic [2:0]       nxt_idx;
  logic [7:0]       data_q;
  logic             parity_q;
  logic             clk_oe, dat_oe, done, err;
  logic             clk_s, dat_s, clk_fall;
  logic             active, timeout, nack, fail;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_cnt;
`endif

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (CLOCK_50),
    .rst      (RESET_H),
    .ps2_clk  (PS2_CLK_IN),
    .ps2_dat  (PS2_DAT_IN),
    .clk_s    (clk_s),
    .dat_s    (dat_s),
    .clk_fall (clk_fall)
  );

  always_comb begin
    active  = (state != IDLE) && (state != INHIBIT);
    timeout = active && (tmo_cnt == TMO_LAST);
    nack    = (state == STOP) && clk_fall && dat_s;
    fail    = timeout || nack;
    nxt_idx = bit_cnt[2:0] + 3'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_H) begin
      state    <= IDLE;
      inh_cnt  <= '0;
      tmo_cnt  <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      clk_oe   <= 1'b0;
      dat_oe   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // Timeout and missing ack share one exit; it outranks every other transition.
      if (fail) begin
        dat_oe  <= 1'b0;
        inh_cnt <= '0;
        tmo_cnt <= '0;
`ifdef PS2_TX_RETRY_EN
        if (retry_cnt != 2'd2) begin
          retry_cnt <= retry_cnt + 2'd1;
          clk_oe    <= 1'b1;
          state     <= INHIBIT;
        end else begin
          clk_oe <= 1'b0;
          err    <= 1'b1;
          state  <= IDLE;
        end
`else
        clk_oe <= 1'b0;
        err    <= 1'b1;
        state  <= IDLE;
`endif
      end else begin
        if (active) tmo_cnt <= tmo_cnt + 20'd1;
        case (state)
          IDLE: if (TX_VALID) begin
            data_q   <= TX_DATA;
            parity_q <= ~^TX_DATA;
            inh_cnt  <= '0;
            clk_oe   <= 1'b1;
            state    <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_cnt <= '0;
`endif
          end
          INHIBIT: if (inh_cnt == INH_LAST) begin
            inh_cnt <= '0;
            tmo_cnt <= '0;
            clk_oe  <= 1'b0;
            dat_oe  <= 1'b1;
            state   <= RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
          RTS: if (clk_fall) begin
            dat_oe  <= ~data_q[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: if (clk_fall) begin
            if (bit_cnt == 4'd7) begin
              dat_oe <= ~parity_q;
              state  <= PARITY;
            end else begin
              dat_oe  <= ~data_q[nxt_idx];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          PARITY: if (clk_fall) begin
            dat_oe <= 1'b0;
            state  <= STOP;
          end
          STOP: if (clk_fall) state <= WAIT_IDLE;
          WAIT_IDLE: if (clk_s && dat_s) begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign TX_READY   = (state == IDLE);
  assign PS2_CLK_OE = clk_oe;
  assign PS2_DAT_OE = dat_oe;
  assign TX_DONE    = done;
  assign TX_ERR     = err;

endmodule
